// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the raw sensor front-end and the sensor_conditioner.
//   Raw*      : asynchronous raw sensor / enable switch levels (into conditioner)
//   Sen*      : debounced sensor levels (out of conditioner)
//   Control   : display enable for the segment cells, 1 = display active
//   Changed   : one-cycle pulse when a debounced sensor toggles while running
//   fsm_state : debug view of the enable sequencer (0 = IDLE, 1 = ARM, 2 = RUN)
// There is no valid/ready handshake here: every signal is a plain level that
// is meaningful on every cycle; Changed is the only event-style signal.
interface sensor_conditioner_if;
  logic       RawF;
  logic       RawD;
  logic       RawE;
  logic       RawA;
  logic       RawEnable;
  logic       SenF;
  logic       SenD;
  logic       SenE;
  logic       SenA;
  logic       Control;
  logic       Changed;
  logic [1:0] fsm_state;

  // Sensor side: drives the raw levels, observes the conditioned outputs.
  modport master (
    output RawF, RawD, RawE, RawA, RawEnable,
    input  SenF, SenD, SenE, SenA, Control, Changed, fsm_state
  );

  // Conditioner side.
  modport slave (
    input  RawF, RawD, RawE, RawA, RawEnable,
    output SenF, SenD, SenE, SenA, Control, Changed, fsm_state
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Sensor conditioner for the vacuum-robot seven-segment display.
// Synchronises and debounces four sensor lines plus the operator enable
// switch, then sequences the display enable (Control) through IDLE/ARM/RUN
// so the display stays blank until the debounced inputs have settled.
// Ports:
//   Clock   : system clock, all state on the rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : sensor_conditioner_if.slave (raw inputs, Sen*/Control/Changed
//             outputs, fsm_state debug view)
// Every output is a flop, so there is no combinational input-to-output path.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  sensor_conditioner_if.slave  bus
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Channel order: 0 = F, 1 = D, 2 = E, 3 = A, 4 = Enable.
  localparam int EN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   stable_next;
  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] cnt_next [NCH];

  state_t           state;
  logic [CNT_W-1:0] settle;
  logic             control;
  logic             changed;

  assign raw = {bus.RawEnable, bus.RawA, bus.RawE, bus.RawD, bus.RawF};

  // Debounce: the stable value follows sync only after sync has disagreed
  // with it on DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stable_next[i] = stable[i];
      cnt_next[i]    = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= stable_next;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Enable sequencer. It acts on the registered debounced enable, so ARM
  // lasts DEBOUNCE_CYCLES cycles before Control rises. Control and Changed
  // are registered alongside the state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      settle  <= '0;
      control <= 1'b0;
      changed <= 1'b0;
    end else begin
      // Sensor toggles are reported only when the edge that made them was
      // taken in RUN; the RUN-entry edge itself was taken in ARM.
      changed <= (state == RUN) && (stable_next[3:0] != stable[3:0]);
      case (state)
        IDLE: begin
          settle  <= '0;
          control <= 1'b0;
          if (stable[EN]) begin
            state <= ARM;
          end
        end
        ARM: begin
          if (!stable[EN]) begin
            state  <= IDLE;
            settle <= '0;
          end else if (settle == LAST) begin
            state   <= RUN;
            settle  <= '0;
            control <= 1'b1;
          end else begin
            settle <= settle + CNT_W'(1);
          end
        end
        RUN: begin
          if (!stable[EN]) begin
            state   <= IDLE;
            control <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          settle  <= '0;
          control <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SenF      = stable[0];
  assign bus.SenD      = stable[1];
  assign bus.SenE      = stable[2];
  assign bus.SenA      = stable[3];
  assign bus.Control   = control;
  assign bus.Changed   = changed;
  assign bus.fsm_state = state;

endmodule
